// File: rtl/seg7_bus_reader.sv
// Reads back a multiplexed active-low 7-segment bus: qualifies each strobed digit
// by stability, decodes it to a hex nibble and publishes a complete NUM_DIGITS word.
module seg7_bus_reader #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    value_valid,
  output logic                    pattern_err,
  output logic [IW-1:0]           err_digit
);

  localparam int unsigned   CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

  logic [NUM_DIGITS+6:0]   sample, prev;
  logic [CW-1:0]           cnt, cnt_next;
  logic                    one_hot, same, capture, legal, complete;
  logic [IW-1:0]           idx;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   seen, seen_or;
  logic [4*NUM_DIGITS-1:0] nibs, nibs_next;

  assign sample  = {digit_en, seg_in};
  assign one_hot = (digit_en != '0) && ((digit_en & (digit_en - 1'b1)) == '0);
  assign same    = (sample == prev);
  // Capture only on the single edge where the count reaches the threshold.
  assign capture = one_hot && same && (cnt == CMAX - 1'b1);
  assign seen_or = seen | digit_en;
  assign complete = capture && legal && (&seen_or);

  always_comb begin
    cnt_next = '0;
    if (one_hot) begin
      if (same) cnt_next = (cnt == CMAX) ? cnt : cnt + 1'b1;
      else      cnt_next = CW'(1);
    end
  end

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (digit_en[i]) idx = IW'(i);
  end

  always_comb begin
    nib   = 4'h0;
    legal = 1'b1;
    case (seg_in)
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    nibs_next = nibs;
    nibs_next[4*idx +: 4] = nib;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev        <= '0;
      cnt         <= '0;
      seen        <= '0;
      nibs        <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      pattern_err <= 1'b0;
      err_digit   <= '0;
    end else begin
      prev        <= sample;
      cnt         <= cnt_next;
      value_valid <= 1'b0;
      // A new illegal capture takes priority over a simultaneous clear.
      if (capture && !legal) begin
        pattern_err <= 1'b1;
        err_digit   <= idx;
      end else if (err_clr) begin
        pattern_err <= 1'b0;
      end
      if (capture && legal) begin
        nibs <= nibs_next;
        if (complete) begin
          value       <= nibs_next;
          value_valid <= 1'b1;
          seen        <= '0;
        end else begin
          seen <= seen_or;
        end
      end
    end
  end

endmodule
